// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load extraction/extension and write-back select,
// driving the register-bank write port plus a sticky halt flag and a retired-instruction counter.
module wb_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_PC   = 32,
  parameter int NB_REG  = 5,
  parameter int NB_CNT  = 32
) (
  input  logic               i_clock,
  input  logic               i_WB_reset,
  input  logic               i_WB_enable,
  input  logic               i_WB_flush,
  input  logic               i_WB_valid,
  input  logic               i_WB_reg_write,
  input  logic               i_WB_mem_to_reg,
  input  logic               i_WB_link,
  input  logic               i_WB_byte_en,
  input  logic               i_WB_halfword_en,
  input  logic               i_WB_word_en,
  input  logic               i_WB_unsigned,
  input  logic [1:0]         i_WB_byte_offset,
  input  logic [NB_DATA-1:0] i_WB_mem_data,
  input  logic [NB_DATA-1:0] i_WB_alu_result,
  input  logic [NB_PC-1:0]   i_WB_pc,
  input  logic [NB_REG-1:0]  i_WB_write_reg,
  input  logic               i_WB_halt,
  output logic [NB_DATA-1:0] o_WB_write_data,
  output logic [NB_REG-1:0]  o_WB_write_reg,
  output logic               o_WB_reg_write,
  output logic               o_WB_halt,
  output logic [NB_CNT-1:0]  o_WB_retired
);

  logic               valid_reg;
  logic               reg_write_reg;
  logic               mem_to_reg_reg;
  logic               link_reg;
  logic               byte_en_reg;
  logic               halfword_en_reg;
  logic               word_en_reg;
  logic               unsigned_reg;
  logic [1:0]         byte_offset_reg;
  logic [NB_DATA-1:0] mem_data_reg;
  logic [NB_DATA-1:0] alu_result_reg;
  logic [NB_PC-1:0]   pc_reg;
  logic [NB_REG-1:0]  write_reg_reg;
  logic               halt_reg;
  logic               halt_flag_reg;
  logic [NB_CNT-1:0]  retired_reg;

  always_ff @(posedge i_clock or negedge i_WB_reset) begin
    if (!i_WB_reset) begin
      valid_reg       <= 1'b0;
      reg_write_reg   <= 1'b0;
      mem_to_reg_reg  <= 1'b0;
      link_reg        <= 1'b0;
      byte_en_reg     <= 1'b0;
      halfword_en_reg <= 1'b0;
      word_en_reg     <= 1'b0;
      unsigned_reg    <= 1'b0;
      byte_offset_reg <= 2'b00;
      mem_data_reg    <= '0;
      alu_result_reg  <= '0;
      pc_reg          <= '0;
      write_reg_reg   <= '0;
      halt_reg        <= 1'b0;
      halt_flag_reg   <= 1'b0;
      retired_reg     <= '0;
    end else if (!halt_flag_reg) begin
      // Once a HALT has retired the stage is frozen until reset.
      if (i_WB_flush) begin
        valid_reg     <= 1'b0;
        reg_write_reg <= 1'b0;
        halt_reg      <= 1'b0;
      end else if (i_WB_enable) begin
        valid_reg       <= i_WB_valid;
        reg_write_reg   <= i_WB_reg_write;
        mem_to_reg_reg  <= i_WB_mem_to_reg;
        link_reg        <= i_WB_link;
        byte_en_reg     <= i_WB_byte_en;
        halfword_en_reg <= i_WB_halfword_en;
        word_en_reg     <= i_WB_word_en;
        unsigned_reg    <= i_WB_unsigned;
        byte_offset_reg <= i_WB_byte_offset;
        mem_data_reg    <= i_WB_mem_data;
        alu_result_reg  <= i_WB_alu_result;
        pc_reg          <= i_WB_pc;
        write_reg_reg   <= i_WB_write_reg;
        halt_reg        <= i_WB_halt;
        if (i_WB_valid) begin
          if (retired_reg != {NB_CNT{1'b1}}) begin
            retired_reg <= retired_reg + 1'b1;
          end
          if (i_WB_halt) begin
            halt_flag_reg <= 1'b1;
          end
        end
      end
    end
  end

  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [NB_DATA-1:0] load_value;
  logic [NB_DATA-1:0] pc_ext;

  always_comb begin
    byte_sel = mem_data_reg[7:0];
    case (byte_offset_reg)
      2'd1:    byte_sel = mem_data_reg[15:8];
      2'd2:    byte_sel = mem_data_reg[23:16];
      2'd3:    byte_sel = mem_data_reg[31:24];
      default: byte_sel = mem_data_reg[7:0];
    endcase
    half_sel   = byte_offset_reg[1] ? mem_data_reg[31:16] : mem_data_reg[15:0];
    load_value = mem_data_reg;
    // Word wins over halfword over byte; no size bit set behaves as a word load.
    if (word_en_reg || !(halfword_en_reg || byte_en_reg)) begin
      load_value = mem_data_reg;
    end else if (halfword_en_reg) begin
      load_value = {{(NB_DATA-16){~unsigned_reg & half_sel[15]}}, half_sel};
    end else begin
      load_value = {{(NB_DATA-8){~unsigned_reg & byte_sel[7]}}, byte_sel};
    end
  end

  generate
    if (NB_PC >= NB_DATA) begin : g_pc_trunc
      assign pc_ext = pc_reg[NB_DATA-1:0];
    end else begin : g_pc_zext
      assign pc_ext = {{(NB_DATA-NB_PC){1'b0}}, pc_reg};
    end
  endgenerate

  assign o_WB_write_data = link_reg ? pc_ext : (mem_to_reg_reg ? load_value : alu_result_reg);
  assign o_WB_write_reg  = write_reg_reg;
  // HALT retires without writing; r0 is hardwired.
  assign o_WB_reg_write  = valid_reg & reg_write_reg & ~halt_reg & (write_reg_reg != '0);
  assign o_WB_halt       = halt_flag_reg;
  assign o_WB_retired    = retired_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus a randomized run against a behavioural model.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        en, fl, vd, rw, m2r, lk, be, he, we, un, ht;
  logic [1:0]  off;
  logic [31:0] md, alu, pc;
  logic [4:0]  wr;
  logic [31:0] o_data;
  logic [4:0]  o_reg;
  logic        o_we;
  logic        o_halt;
  logic [31:0] o_ret;

  int checks;
  int failures;

  // Behavioural model state: the last accepted instruction, halt flag, retired count.
  logic        m_valid, m_rw, m_m2r, m_link, m_b, m_h, m_w, m_u, m_halt, m_hflag;
  logic [1:0]  m_off;
  logic [31:0] m_mem, m_alu, m_pc, m_cnt;
  logic [4:0]  m_reg;

  wb_stage dut (
    .i_clock          (clk),
    .i_WB_reset       (rst_n),
    .i_WB_enable      (en),
    .i_WB_flush       (fl),
    .i_WB_valid       (vd),
    .i_WB_reg_write   (rw),
    .i_WB_mem_to_reg  (m2r),
    .i_WB_link        (lk),
    .i_WB_byte_en     (be),
    .i_WB_halfword_en (he),
    .i_WB_word_en     (we),
    .i_WB_unsigned    (un),
    .i_WB_byte_offset (off),
    .i_WB_mem_data    (md),
    .i_WB_alu_result  (alu),
    .i_WB_pc          (pc),
    .i_WB_write_reg   (wr),
    .i_WB_halt        (ht),
    .o_WB_write_data  (o_data),
    .o_WB_write_reg   (o_reg),
    .o_WB_reg_write   (o_we),
    .o_WB_halt        (o_halt),
    .o_WB_retired     (o_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_data();
    logic [31:0] v;
    if (m_link) return m_pc;
    if (!m_m2r) return m_alu;
    if (m_w || (!m_h && !m_b)) return m_mem;
    if (m_h) begin
      v = m_off[1] ? (m_mem >> 16) : (m_mem & 32'h0000_FFFF);
      if (!m_u && v >= 32'h8000) v = v + 32'hFFFF_0000;
      return v;
    end
    v = (m_mem >> (8 * m_off)) & 32'hFF;
    if (!m_u && v >= 32'h80) v = v + 32'hFFFF_FF00;
    return v;
  endfunction

  function automatic logic model_we();
    return m_valid && m_rw && !m_halt && (m_reg != 5'd0);
  endfunction

  task automatic model_clear();
    {m_valid, m_rw, m_m2r, m_link, m_b, m_h, m_w, m_u, m_halt, m_hflag} = '0;
    m_off = 2'd0; m_mem = 0; m_alu = 0; m_pc = 0; m_cnt = 0; m_reg = 0;
  endtask

  task automatic set_idle();
    en = 1'b1; fl = 1'b0; vd = 1'b0; rw = 1'b0; m2r = 1'b0; lk = 1'b0;
    be = 1'b0; he = 1'b0; we = 1'b0; un = 1'b0; ht = 1'b0; off = 2'd0;
    md = 32'd0; alu = 32'd0; pc = 32'd0; wr = 5'd0;
  endtask

  // Advance one clock edge, apply the model's rules for that edge, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst_n && !m_hflag) begin
      if (fl) begin
        m_valid = 1'b0; m_rw = 1'b0; m_halt = 1'b0;
      end else if (en) begin
        m_valid = vd; m_rw = rw; m_m2r = m2r; m_link = lk; m_b = be; m_h = he; m_w = we;
        m_u = un; m_off = off; m_mem = md; m_alu = alu; m_pc = pc; m_reg = wr; m_halt = ht;
        if (vd) begin
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
          if (ht) m_hflag = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    model_clear();
    vd = 1'b1; rw = 1'b1; wr = 5'd5; alu = 32'hDEAD_BEEF;
    step();
    step();
    checks++;
    if (o_data !== 32'd0 || o_reg !== 5'd0 || o_we !== 1'b0 || o_halt !== 1'b0 || o_ret !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: data=%h reg=%0d we=%b halt=%b ret=%0d required all 0",
               o_data, o_reg, o_we, o_halt, o_ret);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (o_reg !== 5'd5 || o_we !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: reg=%0d we=%b required reg=5 we=1", o_reg, o_we);
    end
    $display("txn reset: reg=%0d we=%b ret=%0d", o_reg, o_we, o_ret);
  endtask

  task automatic test_alu();
    do_reset();
    set_idle();
    vd = 1'b1; rw = 1'b1; wr = 5'd8; alu = 32'h0000_1234; md = 32'hFFFF_FFFF;
    step();
    checks++;
    if (o_data !== 32'h0000_1234 || o_reg !== 5'd8 || o_we !== 1'b1 || o_ret !== 32'd1) begin
      failures++;
      $display("FAIL alu_writeback: data=%h reg=%0d we=%b ret=%0d required 00001234/8/1/1",
               o_data, o_reg, o_we, o_ret);
    end
    $display("txn alu: data=%h reg=%0d we=%b ret=%0d", o_data, o_reg, o_we, o_ret);
  endtask

  task automatic test_loads();
    logic [31:0] exp_v [5];
    logic [2:0]  size_v [5];
    logic        uns_v [5];
    logic [1:0]  off_v [5];
    exp_v  = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F81};
    size_v = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100};
    uns_v  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    off_v  = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd3};
    for (int i = 0; i < 5; i++) begin
      set_idle();
      vd = 1'b1; rw = 1'b1; m2r = 1'b1; wr = 5'd3; md = 32'h80FF_7F81; alu = 32'h1111_1111;
      {we, he, be} = size_v[i];
      un = uns_v[i]; off = off_v[i];
      step();
      checks++;
      if (o_data !== exp_v[i]) begin
        failures++;
        $display("FAIL load_%0d: data=%h required %h", i, o_data, exp_v[i]);
      end
      $display("txn load%0d: data=%h", i, o_data);
    end
  endtask

  task automatic test_link_r0();
    set_idle();
    vd = 1'b1; rw = 1'b1; lk = 1'b1; m2r = 1'b1; pc = 32'h0000_0041; wr = 5'd31;
    alu = 32'h5555_5555; md = 32'hAAAA_AAAA;
    step();
    checks++;
    if (o_data !== 32'h0000_0041 || o_reg !== 5'd31 || o_we !== 1'b1) begin
      failures++;
      $display("FAIL link: data=%h reg=%0d we=%b required 00000041/31/1", o_data, o_reg, o_we);
    end
    set_idle();
    vd = 1'b1; rw = 1'b1; wr = 5'd0; alu = 32'd5;
    step();
    checks++;
    if (o_we !== 1'b0 || o_reg !== 5'd0) begin
      failures++;
      $display("FAIL r0_write: we=%b reg=%0d required we=0 reg=0", o_we, o_reg);
    end
    $display("txn link/r0: data=%h we=%b", o_data, o_we);
  endtask

  task automatic test_stall_flush();
    logic [31:0] held_cnt;
    set_idle();
    vd = 1'b1; rw = 1'b1; wr = 5'd9; alu = 32'h0000_ABCD;
    step();
    held_cnt = m_cnt;
    set_idle();
    en = 1'b0; vd = 1'b1; rw = 1'b1; wr = 5'd12; alu = 32'h0000_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (o_data !== 32'h0000_ABCD || o_reg !== 5'd9 || o_we !== 1'b1 || o_ret !== held_cnt) begin
        failures++;
        $display("FAIL stall_%0d: data=%h reg=%0d we=%b ret=%0d required 0000abcd/9/1/%0d",
                 i, o_data, o_reg, o_we, o_ret, held_cnt);
      end
    end
    en = 1'b1; fl = 1'b1;
    step();
    checks++;
    if (o_we !== 1'b0 || o_ret !== held_cnt) begin
      failures++;
      $display("FAIL flush: we=%b ret=%0d required we=0 ret=%0d", o_we, o_ret, held_cnt);
    end
    $display("txn stall/flush: we=%b ret=%0d", o_we, o_ret);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      en  = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 14) == 0);
      vd  = ($urandom_range(0, 4) != 0);
      rw  = $urandom_range(0, 1);
      m2r = $urandom_range(0, 1);
      lk  = ($urandom_range(0, 7) == 0);
      be  = $urandom_range(0, 1);
      he  = $urandom_range(0, 1);
      we  = $urandom_range(0, 1);
      un  = $urandom_range(0, 1);
      ht  = ($urandom_range(0, 149) == 0);
      off = 2'($urandom_range(0, 3));
      md  = $urandom;
      alu = $urandom;
      pc  = $urandom;
      wr  = 5'($urandom_range(0, 31));
      step();
      checks++;
      if (o_data !== model_data() || o_reg !== m_reg || o_we !== model_we() ||
          o_halt !== m_hflag || o_ret !== m_cnt) begin
        failures++;
        $display("FAIL random_%0d: data=%h reg=%0d we=%b halt=%b ret=%0d required %h/%0d/%b/%b/%0d",
                 n, o_data, o_reg, o_we, o_halt, o_ret,
                 model_data(), m_reg, model_we(), m_hflag, m_cnt);
      end
    end
    $display("txn random: ret=%0d halt=%b", o_ret, o_halt);
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_idle();
      vd = 1'b1; rw = 1'b1; wr = 5'(i + 1); alu = 32'(i * 3);
      step();
    end
    checks++;
    if (o_ret !== 32'd4) begin
      failures++;
      $display("FAIL pre_halt_count: ret=%0d required 4", o_ret);
    end
    set_idle();
    vd = 1'b1; rw = 1'b1; ht = 1'b1; wr = 5'd7;
    step();
    checks++;
    if (o_halt !== 1'b1 || o_ret !== 32'd5 || o_we !== 1'b0) begin
      failures++;
      $display("FAIL halt_retire: halt=%b ret=%0d we=%b required 1/5/0", o_halt, o_ret, o_we);
    end
    set_idle();
    for (int i = 0; i < 3; i++) begin
      vd = 1'b1; rw = 1'b1; wr = 5'd10; alu = 32'h77;
      step();
      checks++;
      if (o_halt !== 1'b1 || o_ret !== 32'd5 || o_we !== 1'b0) begin
        failures++;
        $display("FAIL halt_frozen_%0d: halt=%b ret=%0d we=%b required 1/5/0", i, o_halt, o_ret, o_we);
      end
    end
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (o_halt !== 1'b0 || o_ret !== 32'd0 || o_we !== 1'b0 || o_data !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: halt=%b ret=%0d we=%b data=%h required all 0", o_halt, o_ret, o_we, o_data);
    end
    step();
    rst_n = 1'b1;
    $display("txn halt: halt=%b ret=%0d", o_halt, o_ret);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    set_idle();
    model_clear();
    test_reset();
    test_alu();
    test_loads();
    test_link_r0();
    test_stall_flush();
    test_random();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
